// File: rtl/limn2600_bus_pkg.sv
// Shared types and constants for the Limn2600 SRAM arbiter.
package limn2600_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_RECOVER = 2'd2
    } arb_state_e;

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_e;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic is_aligned(input logic [31:0] addr);
        return (addr[1:0] & WORD_ALIGN_MASK) == 2'b00;
    endfunction

endpackage

// File: rtl/limn2600_mem_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of the Limn2600 SRAM with
// misalignment rejection and a bounded wait on the SRAM's registered rdy.
module limn2600_mem_arbiter
    import limn2600_bus_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [31:0]           i_addr,
    output logic                  i_ack,
    output logic                  i_err,
    output logic [DATA_WIDTH-1:0] i_rdata,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [31:0]           d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_ack,
    output logic                  d_err,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  mem_cs,
    output logic                  mem_we,
    output logic [31:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_rdy,
    input  logic [DATA_WIDTH-1:0] mem_rdata
);

    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    arb_state_e            state_q, state_d;
    grant_e                last_grant_q, last_grant_d;
    grant_e                grant_q, grant_d;
    logic [7:0]            cnt_q, cnt_d;
    logic                  mem_cs_q, mem_cs_d;
    logic                  mem_we_q, mem_we_d;
    logic [31:0]           mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic                  i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic                  d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [DATA_WIDTH-1:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    grant_e                pick_s;
    logic [31:0]           pick_addr_s;
    logic [7:0]            cnt_inc_s;

    // Round-robin pick: on a tie the port not granted last time wins.
    always_comb begin
        pick_s = GRANT_FETCH;
        if (i_req && d_req) begin
            pick_s = (last_grant_q == GRANT_FETCH) ? GRANT_DATA : GRANT_FETCH;
        end else if (d_req) begin
            pick_s = GRANT_DATA;
        end else begin
            pick_s = GRANT_FETCH;
        end
        pick_addr_s = (pick_s == GRANT_DATA) ? d_addr : i_addr;
        cnt_inc_s   = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    end

    // Next-state and registered-output logic; acks default low so they pulse once.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        cnt_d        = cnt_inc_s;
        mem_cs_d     = mem_cs_q;
        mem_we_d     = mem_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        i_ack_d      = 1'b0;
        i_err_d      = 1'b0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = 8'd0;
                if (i_req || d_req) begin
                    grant_d      = pick_s;
                    last_grant_d = pick_s;
                    if (!is_aligned(pick_addr_s)) begin
                        state_d = ST_RECOVER;
                        if (pick_s == GRANT_DATA) begin
                            d_ack_d   = 1'b1;
                            d_err_d   = 1'b1;
                            d_rdata_d = {DATA_WIDTH{1'b0}};
                        end else begin
                            i_ack_d   = 1'b1;
                            i_err_d   = 1'b1;
                            i_rdata_d = {DATA_WIDTH{1'b0}};
                        end
                    end else begin
                        state_d     = ST_ACCESS;
                        mem_cs_d    = 1'b1;
                        mem_addr_d  = pick_addr_s;
                        mem_we_d    = (pick_s == GRANT_DATA) && d_we;
                        mem_wdata_d = (pick_s == GRANT_DATA) ? d_wdata : mem_wdata_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (mem_rdy || (cnt_q == CNT_LAST)) begin
                    state_d  = ST_RECOVER;
                    cnt_d    = 8'd0;
                    mem_cs_d = 1'b0;
                    // A store leaves rdata untouched; a timeout forces it to zero.
                    if (grant_q == GRANT_DATA) begin
                        d_ack_d = 1'b1;
                        d_err_d = !mem_rdy;
                        if (!mem_rdy) begin
                            d_rdata_d = {DATA_WIDTH{1'b0}};
                        end else if (!mem_we_q) begin
                            d_rdata_d = mem_rdata;
                        end else begin
                            d_rdata_d = d_rdata_q;
                        end
                    end else begin
                        i_ack_d   = 1'b1;
                        i_err_d   = !mem_rdy;
                        i_rdata_d = mem_rdy ? mem_rdata : {DATA_WIDTH{1'b0}};
                    end
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_RECOVER: begin
                if (!mem_rdy || (cnt_q == CNT_LAST)) begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end else begin
                    state_d = ST_RECOVER;
                end
            end
            default: begin
                state_d  = ST_IDLE;
                cnt_d    = 8'd0;
                mem_cs_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops mem_cs immediately.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            last_grant_q <= GRANT_FETCH;
            grant_q      <= GRANT_FETCH;
            cnt_q        <= 8'd0;
            mem_cs_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= 32'd0;
            mem_wdata_q  <= {DATA_WIDTH{1'b0}};
            i_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_rdata_q    <= {DATA_WIDTH{1'b0}};
            d_rdata_q    <= {DATA_WIDTH{1'b0}};
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            cnt_q        <= cnt_d;
            mem_cs_q     <= mem_cs_d;
            mem_we_q     <= mem_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            i_ack_q      <= i_ack_d;
            i_err_q      <= i_err_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    assign i_ack     = i_ack_q;
    assign i_err     = i_err_q;
    assign i_rdata   = i_rdata_q;
    assign d_ack     = d_ack_q;
    assign d_err     = d_err_q;
    assign d_rdata   = d_rdata_q;
    assign mem_cs    = mem_cs_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_limn2600_mem_arbiter.sv
// Bench for limn2600_mem_arbiter: registered SRAM responder plus a
// transaction-level model predicting ack cycle, err and rdata per port.
module tb_limn2600_mem_arbiter;

    localparam int DW = 32;
    localparam int TO = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_req = 1'b0;
    logic [31:0]   i_addr = 32'd0;
    logic          i_ack, i_err;
    logic [DW-1:0] i_rdata;
    logic          d_req = 1'b0;
    logic          d_we = 1'b0;
    logic [31:0]   d_addr = 32'd0;
    logic [DW-1:0] d_wdata = 32'd0;
    logic          d_ack, d_err;
    logic [DW-1:0] d_rdata;
    logic          mem_cs, mem_we;
    logic [31:0]   mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_rdy;
    logic [DW-1:0] mem_rdata;

    limn2600_mem_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
        .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdy(mem_rdy), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return (i == 4) ? 32'hDEADBEEF : ((32'(i) * 32'h01010101) ^ 32'hA5A5A5A5);
    endfunction

    // Registered SRAM: rdy and data_out follow cs by one cycle; can be stuck not-ready.
    logic [DW-1:0] ram [0:255];
    logic          sram_stuck = 1'b0;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_rdy   <= 1'b0;
            mem_rdata <= 32'd0;
            for (int i = 0; i < 256; i++) ram[i] <= init_word(i);
        end else begin
            mem_rdy <= mem_cs && !sram_stuck;
            if (mem_cs && !sram_stuck) begin
                if (mem_we) ram[mem_addr[9:2]] <= mem_wdata;
                else        mem_rdata <= ram[mem_addr[9:2]];
            end
        end
    end

    logic [DW-1:0] shadow [0:255];
    bit            m_last_data;
    logic [DW-1:0] m_i_rdata, m_d_rdata;
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_last_data = 1'b0;
        m_i_rdata   = 32'd0;
        m_d_rdata   = 32'd0;
        for (int i = 0; i < 256; i++) shadow[i] = init_word(i);
    endtask

    // Issue one or two simultaneous requests and check the outcome of each.
    task automatic run_txn(input bit fr, input logic [31:0] fa, input bit dr,
                           input bit dwe, input logic [31:0] da, input logic [31:0] dwd);
        int lat_i, lat_d, t0, cs_exp, lat, dur;
        int i_cnt, d_cnt, i_cyc, d_cyc, cs_cnt;
        bit i_err_e, d_err_e, i_err_o, d_err_o, is_data, active, err_e;
        logic [31:0] i_rd_e, d_rd_e, i_rd_o, d_rd_o, addr, rd;
        bit data_first;

        t0 = 0; cs_exp = 0; lat_i = -1; lat_d = -1;
        i_err_e = 1'b0; d_err_e = 1'b0; i_rd_e = 32'd0; d_rd_e = 32'd0;
        data_first = dr && (!fr || !m_last_data);
        for (int s = 0; s < 2; s++) begin
            is_data = (s == 0) ? data_first : !data_first;
            active  = is_data ? dr : fr;
            if (active) begin
                addr = is_data ? da : fa;
                if (addr[1:0] != 2'b00) begin
                    lat = 1; dur = 2; err_e = 1'b1; rd = 32'd0;
                end else if (sram_stuck) begin
                    lat = TO + 1; dur = TO + 2; err_e = 1'b1; rd = 32'd0; cs_exp += TO;
                end else begin
                    lat = 3; dur = 5; err_e = 1'b0; cs_exp += 2;
                    if (is_data && dwe) begin
                        shadow[addr[9:2]] = dwd;
                        rd = m_d_rdata;
                    end else begin
                        rd = shadow[addr[9:2]];
                    end
                end
                if (is_data) begin
                    lat_d = t0 + lat; d_err_e = err_e; d_rd_e = rd; m_d_rdata = rd;
                end else begin
                    lat_i = t0 + lat; i_err_e = err_e; i_rd_e = rd; m_i_rdata = rd;
                end
                t0 += dur;
                m_last_data = is_data;
            end
        end

        i_req = fr; i_addr = fa; d_req = dr; d_we = dwe; d_addr = da; d_wdata = dwd;
        i_cnt = 0; d_cnt = 0; i_cyc = 0; d_cyc = 0; cs_cnt = 0;
        i_err_o = 1'b0; d_err_o = 1'b0; i_rd_o = 32'd0; d_rd_o = 32'd0;
        for (int k = 1; k <= t0; k++) begin
            @(negedge clk);
            if (mem_cs) cs_cnt++;
            if (i_ack) begin
                i_cnt++; i_cyc = k; i_err_o = i_err; i_rd_o = i_rdata; i_req = 1'b0;
            end
            if (d_ack) begin
                d_cnt++; d_cyc = k; d_err_o = d_err; d_rd_o = d_rdata; d_req = 1'b0;
            end
        end
        i_req = 1'b0; d_req = 1'b0;

        if (fr) begin
            check("i_ack_cycle", 64'(i_cyc), 64'(lat_i));
            check("i_err", 64'(i_err_o), 64'(i_err_e));
            check("i_rdata", 64'(i_rd_o), 64'(i_rd_e));
        end
        if (dr) begin
            check("d_ack_cycle", 64'(d_cyc), 64'(lat_d));
            check("d_err", 64'(d_err_o), 64'(d_err_e));
            check("d_rdata", 64'(d_rd_o), 64'(d_rd_e));
        end
        check("i_ack_count", 64'(i_cnt), fr ? 64'd1 : 64'd0);
        check("d_ack_count", 64'(d_cnt), dr ? 64'd1 : 64'd0);
        check("cs_cycles", 64'(cs_cnt), 64'(cs_exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acks_in_rst;
        bit fr, dr, dwe;
        logic [31:0] fa, da;

        model_reset();
        repeat (2) @(negedge clk);
        check("rst_mem_cs", 64'(mem_cs), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_acks", {62'd0, i_ack, d_ack}, 64'd0);
        check("rst_errs", {62'd0, i_err, d_err}, 64'd0);
        check("rst_mem_addr", 64'(mem_addr), 64'd0);
        check("rst_mem_wdata", 64'(mem_wdata), 64'd0);
        check("rst_rdata", {i_rdata, d_rdata}, 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Tie right after reset: data first, then alternating pairs.
        for (int p = 0; p < 5; p++)
            run_txn(1'b1, 32'(p * 8 + 16), 1'b1, 1'b0, 32'(p * 8 + 20), 32'd0);

        run_txn(1'b1, 32'h00000010, 1'b0, 1'b0, 32'd0, 32'd0);
        check("fetch_deadbeef", 64'(i_rdata), 64'hDEADBEEF);

        run_txn(1'b0, 32'd0, 1'b1, 1'b1, 32'h00F80020, 32'h12345678);
        run_txn(1'b0, 32'd0, 1'b1, 1'b0, 32'h00F80020, 32'd0);
        check("load_back", 64'(d_rdata), 64'h12345678);

        run_txn(1'b0, 32'd0, 1'b1, 1'b0, 32'h00000006, 32'd0);

        sram_stuck = 1'b1;
        run_txn(1'b1, 32'h00000010, 1'b0, 1'b0, 32'd0, 32'd0);
        sram_stuck = 1'b0;
        run_txn(1'b1, 32'h00000010, 1'b0, 1'b0, 32'd0, 32'd0);

        for (int n = 0; n < 40; n++) begin
            fr  = 1'($urandom_range(0, 1));
            dr  = 1'($urandom_range(0, 1));
            if (!fr && !dr) fr = 1'b1;
            dwe = 1'($urandom_range(0, 1));
            fa  = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            da  = {22'd0, 8'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 4) == 0) fa[1:0] = 2'($urandom_range(1, 3));
            if ($urandom_range(0, 4) == 0) da[1:0] = 2'($urandom_range(1, 3));
            run_txn(fr, fa, dr, dwe, da, $urandom);
        end

        // Asynchronous reset in the middle of an access.
        i_req = 1'b1; i_addr = 32'h00000020;
        @(negedge clk);
        check("cs_before_rst", 64'(mem_cs), 64'd1);
        #2 rst = 1'b0;
        #1 check("cs_async_drop", 64'(mem_cs), 64'd0);
        i_req = 1'b0;
        acks_in_rst = 0;
        repeat (3) begin
            @(negedge clk);
            if (i_ack || d_ack) acks_in_rst++;
        end
        rst = 1'b1;
        model_reset();
        @(negedge clk);
        if (i_ack || d_ack) acks_in_rst++;
        check("no_ack_on_rst", 64'(acks_in_rst), 64'd0);
        check("i_rdata_after_rst", 64'(i_rdata), 64'(m_i_rdata));
        run_txn(1'b1, 32'h00000010, 1'b0, 1'b0, 32'd0, 32'd0);
        run_txn(1'b1, 32'h00000011, 1'b1, 1'b0, 32'h00000024, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
